// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: FSM state encoding and
// the index-width helper used by the controller and its frame buffer.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    WAIT_IDLE = 3'd1,
    LOAD      = 3'd2,
    WAIT      = 3'd3,
    UNLOAD    = 3'd4
  } ctrl_state_t;

  // Width of a sample/bin index for an n-point frame (at least one bit).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// N x MSB sample store for one input frame: one synchronous write port fed
// by the input handshake, one combinational read port indexed by the loader.
module fft_frame_buf
  import fft_ctrl_pkg::*;
#(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [addr_width(N)-1:0] waddr,
  input  logic [MSB-1:0]           wdata,
  input  logic [addr_width(N)-1:0] raddr,
  output logic [MSB-1:0]           rdata
);

  logic [MSB-1:0] mem [N];

  // Sample write; contents need no reset because every frame overwrites all N slots
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame scheduler around the FFT core: gathers N input samples, bursts them
// into the core, waits for completion and serialises the N result bins.
// Optional WAIT-state watchdog enabled with `define FFT_CTRL_TIMEOUT_EN.
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N              = 16,
  parameter int MSB            = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [MSB-1:0]        s_data,
  output logic                  s_ready,
  output logic [MSB-1:0]        fft_data_in,
  output logic [$clog2(N)-1:0]  fft_addr,
  output logic                  fft_insert_data,
  input  logic [MSB*N-1:0]      fft_data_out,
  input  logic                  fft_busy,
  input  logic                  fft_finish,
  output logic                  m_valid,
  output logic [MSB-1:0]        m_data,
  output logic [$clog2(N)-1:0]  m_index,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  frame_done,
  output logic                  timeout_err
);

  localparam int AW = addr_width(N);

  ctrl_state_t state, state_nxt;

  logic [AW-1:0]    wr_cnt;
  logic [AW-1:0]    ld_cnt;
  logic [AW-1:0]    rd_cnt;
  logic [MSB-1:0]   buf_rdata;
  logic [MSB*N-1:0] result_p0;

  logic             ld_vld_p0;
  logic [AW-1:0]    ld_addr_p0;
  logic [MSB-1:0]   ld_data_p0;

  logic accept;
  logic last_beat;
  logic last_load;
  logic last_bin;
  logic capture;
  logic wd_expire;

  assign accept    = s_valid & s_ready;
  assign last_beat = accept && (wr_cnt == AW'(N - 1));
  assign last_load = (state == LOAD) && (ld_cnt == AW'(N - 1));
  assign last_bin  = (state == UNLOAD) && m_ready && (rd_cnt == AW'(N - 1));
  assign capture   = (state == WAIT) && fft_finish;

  fft_frame_buf #(
    .N   (N),
    .MSB (MSB)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_cnt),
    .wdata (s_data),
    .raddr (ld_cnt),
    .rdata (buf_rdata)
  );

  // State register; reset lands in FILL, which drives nothing toward the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state decode and the serial bin output, a pure function of state/rd_cnt
  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_data    = '0;
    m_index   = '0;
    m_last    = 1'b0;
    case (state)
      FILL:      if (last_beat) state_nxt = WAIT_IDLE;
      WAIT_IDLE: if (!fft_busy) state_nxt = LOAD;
      LOAD:      if (last_load) state_nxt = WAIT;
      WAIT: begin
        if (capture)        state_nxt = UNLOAD;
        else if (wd_expire) state_nxt = FILL;
      end
      UNLOAD: begin
        m_valid = 1'b1;
        m_data  = result_p0[int'(rd_cnt) * MSB +: MSB];
        m_index = rd_cnt;
        m_last  = (rd_cnt == AW'(N - 1));
        if (last_bin) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Input side: ready is registered from the next state so it drops right after the N-th beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      s_ready <= (state_nxt == FILL);
      if (accept) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // ---- p0: registered core load burst, one buffer word per cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt     <= '0;
      ld_vld_p0  <= 1'b0;
      ld_addr_p0 <= '0;
      ld_data_p0 <= '0;
    end else if (state == LOAD) begin
      ld_cnt     <= ld_cnt + 1'b1;
      ld_vld_p0  <= 1'b1;
      ld_addr_p0 <= ld_cnt;
      ld_data_p0 <= buf_rdata;
    end else begin
      ld_cnt     <= '0;
      ld_vld_p0  <= 1'b0;
      ld_addr_p0 <= '0;
      ld_data_p0 <= '0;
    end
  end

  assign fft_insert_data = ld_vld_p0;
  assign fft_addr        = ld_addr_p0;
  assign fft_data_in     = ld_data_p0;

  // ---- p0: core result capture; finish strobes outside WAIT never load it ----
  always_ff @(posedge clk) begin
    if (capture) result_p0 <= fft_data_out;
  end

  // Output read pointer and the completion pulse after the last bin handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_bin;
      if ((state == UNLOAD) && m_ready) rd_cnt <= rd_cnt + 1'b1;
    end
  end

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  assign wd_expire = (state == WAIT) && !fft_finish && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts WAIT cycles, flags a lost core completion and stays set until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      else               wd_cnt <= '0;
      if (wd_expire) timeout_err <= 1'b1;
    end
  end
`else
  // No watchdog: WAIT blocks until the core finishes; the flag is constant low
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule
